// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for the hh:mm:ss clock
//   Gates the 1 Hz count enable, sequences RUN/SET_HH/SET_MM/SET_SS on mode
//   presses, drives increment loads (with auto-repeat) into the time counters,
//   produces a blink phase for the edited field and falls back to RUN after
//   TIMEOUT_S idle seconds.
// Ports:
//   clk_i          system clock
//   rst_n_i        synchronous active-low reset
//   tick_1hz_i     one-cycle 1 Hz pulse
//   btn_mode_i     debounced mode button (level)
//   btn_inc_i      debounced increment button (level)
//   cur_hh_i/mm/ss current counter values
//   run_en_o       seconds-counter enable
//   load_*_o       one-cycle load strobes
//   load_data_o    value for the strobed counter (hh uses [4:0])
//   blink_o        blank phase of the selected field
//   mode_o         0=RUN 1=SET_HH 2=SET_MM 3=SET_SS
module clock_set_ctrl #(
    parameter int HOLD_CYC  = 25_000_000,
    parameter int RPT_CYC   = 5_000_000,
    parameter int BLINK_CYC = 12_500_000,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       tick_1hz_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic [4:0] cur_hh_i,
    input  logic [5:0] cur_mm_i,
    input  logic [5:0] cur_ss_i,
    output logic       run_en_o,
    output logic       load_hh_o,
    output logic       load_mm_o,
    output logic       load_ss_o,
    output logic [5:0] load_data_o,
    output logic       blink_o,
    output logic [1:0] mode_o
);
    localparam int HMAX = HOLD_CYC > RPT_CYC ? HOLD_CYC : RPT_CYC;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int BW   = $clog2(BLINK_CYC + 1);
    localparam int TW   = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_e;

    state_e        state_q, state_d;
    logic          mode_prev_q, inc_prev_q;
    logic          armed_q, armed_d;
    logic          rpt_q, rpt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [TW-1:0] to_q, to_d;
    logic [2:0]    load_q, load_d;
    logic [5:0]    data_q, data_d;
    logic          in_set, mode_press, inc_press, set_press, rpt_fire, timeout, do_load, restart;
    logic [5:0]    sel, sel_max;

    always_comb begin
        in_set      = state_q != RUN;
        mode_press  = btn_mode_i & ~mode_prev_q;
        // mode wins a same-cycle tie, so the inc press is dropped entirely
        inc_press   = btn_inc_i & ~inc_prev_q & ~mode_press;
        set_press   = inc_press & in_set;
        // armed_q means inc has been held continuously since a press in this state;
        // the hold counter is compared against the first-repeat or the steady-repeat period
        rpt_fire    = in_set & armed_q & btn_inc_i & ~mode_press &
                      (hold_q == (rpt_q ? HW'(RPT_CYC) : HW'(HOLD_CYC)));
        timeout     = in_set & tick_1hz_i & ~mode_press & ~inc_press & (to_q == TW'(TIMEOUT_S - 1));
        state_d     = mode_press ? state_e'(state_q + 2'd1) : timeout ? RUN : state_q;
        do_load     = set_press | rpt_fire;
        sel         = state_q == SET_HH ? {1'b0, cur_hh_i} : state_q == SET_MM ? cur_mm_i : cur_ss_i;
        sel_max     = state_q == SET_HH ? 6'd23 : 6'd59;
        load_d      = !do_load ? 3'b000 : state_q == SET_HH ? 3'b100 : state_q == SET_MM ? 3'b010 : 3'b001;
        data_d      = do_load ? (sel == sel_max ? 6'd0 : sel + 6'd1) : data_q;
        armed_d     = set_press | (armed_q & btn_inc_i & ~mode_press & (state_d == state_q));
        hold_d      = (set_press | rpt_fire) ? HW'(1) : armed_d ? hold_q + HW'(1) : '0;
        rpt_d       = armed_d & ~set_press & (rpt_q | rpt_fire);
        to_d        = (~in_set | mode_press | inc_press | timeout) ? '0 : tick_1hz_i ? to_q + TW'(1) : to_q;
        // the field is shown right after any edit or state change, then blinks
        restart     = (state_d != state_q) | do_load | (state_d == RUN);
        blink_cnt_d = (restart | (blink_cnt_q == BW'(BLINK_CYC - 1))) ? '0 : blink_cnt_q + BW'(1);
        blink_d     = restart ? 1'b0 : (blink_cnt_q == BW'(BLINK_CYC - 1)) ? ~blink_q : blink_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            rpt_q       <= 1'b0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            to_q        <= '0;
            load_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode_i;
            inc_prev_q  <= btn_inc_i;
            armed_q     <= armed_d;
            rpt_q       <= rpt_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            to_q        <= to_d;
            load_q      <= load_d;
            data_q      <= data_d;
        end
    end

    assign run_en_o    = tick_1hz_i & rst_n_i & (state_q == RUN);
    assign load_hh_o   = load_q[2];
    assign load_mm_o   = load_q[1];
    assign load_ss_o   = load_q[0];
    assign load_data_o = data_q;
    assign blink_o     = blink_q;
    assign mode_o      = state_q;
endmodule
